// File: rtl/lcd_i2c_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lcd_i2c_master                                            |
// | Purpose  : Byte-level I2C master with an Avalon-MM register port.    |
// |            Generates START / 8 data bits + ACK / STOP with slave     |
// |            clock stretching, for the LCD/EEPROM open-drain bus.      |
// | Options  : LCD_I2C_MASTER_IRQ_EN adds a completion interrupt.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module lcd_i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
`ifdef LCD_I2C_MASTER_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BYTE  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [15:0] c_load = 16'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [1:0]  r_q;
  logic [3:0]  r_bit;
  logic        r_busy;
  logic        r_rx_nack;
  logic        r_scl_low;
  logic        r_stop;
  logic        r_wr;
  logic        r_rd;
  logic        r_nack_out;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic [7:0]  r_sh;
  logic        w_wr_data;
  logic        w_wr_cmd;
  logic        w_cmd_ok;
  logic        w_stretch;
  logic        w_tick;
  logic        w_phase_end;
  logic        w_irq;
  logic        w_unused;

  assign w_wr_data = chipselect & ~write_n & (address == 2'd0);
  assign w_wr_cmd  = chipselect & ~write_n & (address == 2'd1);
  // A command needs at least one phase, and WR/RD are mutually exclusive.
  assign w_cmd_ok  = w_wr_cmd & ~r_busy & (|writedata[3:0]) & ~(writedata[2] & writedata[3]);
  // SCL released by us but still low on the pad: slave is stretching.
  assign w_stretch   = ~scl_oe & ~scl_in;
  assign w_tick      = (r_state != S_IDLE) & (r_cnt == 16'd0) & ~w_stretch;
  assign w_phase_end = w_tick & (r_q == 2'd3) & ((r_state != S_BYTE) | (r_bit == 4'd8));
  assign w_unused    = ^writedata[31:8];

  // Phase state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Phase sequencing: START -> BYTE -> STOP -> IDLE, skipping unrequested phases.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_ok) begin
          if (writedata[0])                    w_next = S_START;
          else if (writedata[2] | writedata[3]) w_next = S_BYTE;
          else                                  w_next = S_STOP;
        end
      end
      S_START: begin
        if (w_phase_end) begin
          if (r_wr | r_rd) w_next = S_BYTE;
          else if (r_stop) w_next = S_STOP;
          else             w_next = S_IDLE;
        end
      end
      S_BYTE: begin
        if (w_phase_end) w_next = r_stop ? S_STOP : S_IDLE;
      end
      S_STOP: begin
        if (w_phase_end) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pad drive per phase and quarter; idle keeps SCL low after a START or BYTE.
  always_comb begin
    scl_oe = r_scl_low;
    sda_oe = 1'b0;
    case (r_state)
      S_START: begin
        case (r_q)
          2'd0:    begin scl_oe = r_scl_low; sda_oe = 1'b0; end
          2'd1:    begin scl_oe = 1'b0;      sda_oe = 1'b0; end
          2'd2:    begin scl_oe = 1'b0;      sda_oe = 1'b1; end
          default: begin scl_oe = 1'b1;      sda_oe = 1'b1; end
        endcase
      end
      S_BYTE: begin
        scl_oe = (r_q == 2'd0) | (r_q == 2'd3);
        if (r_bit == 4'd8) sda_oe = r_wr ? 1'b0 : ~r_nack_out;
        else               sda_oe = r_wr & ~r_sh[7];
      end
      S_STOP: begin
        case (r_q)
          2'd0:    begin scl_oe = 1'b1; sda_oe = 1'b1; end
          2'd1:    begin scl_oe = 1'b0; sda_oe = 1'b1; end
          default: begin scl_oe = 1'b0; sda_oe = 1'b0; end
        endcase
      end
      default: ;
    endcase
  end

  // Quarter timer, bit counter, shift register and status bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= 16'd0;
      r_q        <= 2'd0;
      r_bit      <= 4'd0;
      r_busy     <= 1'b0;
      r_rx_nack  <= 1'b0;
      r_scl_low  <= 1'b0;
      r_stop     <= 1'b0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_nack_out <= 1'b0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_sh       <= 8'h00;
    end else begin
      if (w_wr_data) r_tx <= writedata[7:0];
      if (r_state == S_IDLE) begin
        if (w_cmd_ok) begin
          r_busy     <= 1'b1;
          r_cnt      <= c_load;
          r_q        <= 2'd0;
          r_bit      <= 4'd0;
          r_stop     <= writedata[1];
          r_wr       <= writedata[2];
          r_rd       <= writedata[3];
          r_nack_out <= writedata[4];
          r_sh       <= r_tx;
        end
      end else if (w_stretch) begin
        r_cnt <= c_load;
      end else if (r_cnt != 16'd0) begin
        r_cnt <= r_cnt - 16'd1;
      end else begin
        r_cnt <= c_load;
        r_q   <= r_q + 2'd1;
        if (r_state == S_BYTE) begin
          if ((r_q == 2'd2) && (r_bit != 4'd8) && r_rd) r_sh <= {r_sh[6:0], sda_in};
          if ((r_q == 2'd2) && (r_bit == 4'd8) && r_wr) r_rx_nack <= sda_in;
          if ((r_q == 2'd3) && (r_bit != 4'd8)) begin
            r_bit <= r_bit + 4'd1;
            if (r_wr) r_sh <= {r_sh[6:0], 1'b0};
          end
        end
        if (w_phase_end) begin
          r_bit     <= 4'd0;
          r_scl_low <= (r_state != S_STOP);
          if ((r_state == S_BYTE) && r_rd) r_rx <= r_sh;
          if (w_next == S_IDLE) begin
            r_busy <= 1'b0;
            r_cnt  <= 16'd0;
          end
        end
      end
    end
  end

`ifdef LCD_I2C_MASTER_IRQ_EN
  logic r_irq;
  logic w_wr_status;
  assign w_wr_status = chipselect & ~write_n & (address == 2'd2);

  // Completion interrupt: set when busy falls, cleared by any STATUS write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     r_irq <= 1'b0;
    else if (w_phase_end && (w_next == S_IDLE))    r_irq <= 1'b1;
    else if (w_wr_status)                          r_irq <= 1'b0;
  end

  assign irq   = r_irq;
  assign w_irq = r_irq;
`else
  assign w_irq = 1'b0;
`endif

  // Register read mux, zero wait states.
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata[7:0] = r_rx;
      2'd2:    readdata[2:0] = {w_irq, r_rx_nack, r_busy};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_i2c_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_lcd_i2c_master                                         |
// | Purpose  : Directed bench for lcd_i2c_master with a passive I2C      |
// |            slave model and pull-ups on SCL/SDA.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_lcd_i2c_master;

  localparam int c_div = 4;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [31:0] readdata;
  logic        scl_oe;
  logic        sda_oe;
  logic        scl_hold    = 1'b0;
  logic        slv_sda_low = 1'b0;
  logic        scl_bus;
  logic        sda_bus;
`ifdef LCD_I2C_MASTER_IRQ_EN
  logic        irq;
`endif

  // Slave model controls and observations.
  logic        slv_en   = 1'b0;
  logic        slv_read = 1'b0;
  logic        slv_ack  = 1'b1;
  logic [7:0]  slv_tx   = 8'h00;
  logic [7:0]  slv_rx   = 8'h00;
  logic        slv_ack_seen = 1'b0;
  int          slv_f    = 0;
  int          slv_r    = 0;
  int          chg_cnt  = 0;
  int          stop_cnt = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  // Open-drain wiring with pull-ups.
  assign scl_bus = ~scl_oe & ~scl_hold;
  assign sda_bus = ~sda_oe & ~slv_sda_low;

  always #5 clk = ~clk;

  lcd_i2c_master #(.CLK_DIV(c_div)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_in     (scl_bus),
    .sda_in     (sda_bus),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe)
`ifdef LCD_I2C_MASTER_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Passive slave: detects START/STOP, samples on SCL rise, drives on SCL fall.
  always @(scl_bus or sda_bus) begin
    if (scl_bus && prev_scl && (sda_bus != prev_sda)) begin
      chg_cnt++;
      if (!sda_bus) begin
        slv_f = 0;
        slv_r = 0;
      end else begin
        stop_cnt++;
      end
    end
    if (scl_bus && !prev_scl) begin
      if (slv_r < 8) slv_rx = {slv_rx[6:0], sda_bus};
      else if (slv_r == 8) slv_ack_seen = sda_bus;
      slv_r++;
    end
    if (!scl_bus && prev_scl) begin
      if (!slv_en)         slv_sda_low = 1'b0;
      else if (slv_f < 8)  slv_sda_low = slv_read ? ~slv_tx[7 - slv_f] : 1'b0;
      else if (slv_f == 8) slv_sda_low = slv_read ? 1'b0 : slv_ack;
      else                 slv_sda_low = 1'b0;
      slv_f++;
    end
    prev_scl = scl_bus;
    prev_sda = sda_bus;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Counts clock edges until busy reads 0, bounded by budget.
  task automatic wait_idle(input int budget, output int n);
    address = 2'd2;
    n = 0;
    while (n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (readdata[0] == 1'b0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int n;
    int c0;
    int s0;
    int r0;

    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    bus_rd(2'd2, v); chk("rst_status", v, 32'd0);
    bus_rd(2'd0, v); chk("rst_data", v, 32'd0);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_rd(2'd3, v); chk("addr3_read", v, 32'd0);

    // START|STOP|WR 0xA5, slave ACKs.
    slv_en = 1'b1; slv_read = 1'b0; slv_ack = 1'b1;
    s0 = stop_cnt;
    bus_wr(2'd0, 32'h0000_00A5);
    bus_rd(2'd0, v); chk("data_reads_rx", v, 32'd0);
    bus_wr(2'd1, 32'h07);
    bus_rd(2'd2, v); chk("wr_busy_next", {31'd0, v[0]}, 32'd1);
    wait_idle(1000, n);
    chk("wr_duration", n, 32'd176);
    chk("wr_bits", {24'd0, slv_rx}, 32'hA5);
    chk("wr_ack_seen", {31'd0, slv_ack_seen}, 32'd0);
    bus_rd(2'd2, v); chk("wr_status", v & 32'h3, 32'd0);
    chk("wr_stop_cnt", stop_cnt - s0, 32'd1);
    chk("wr_end_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
`ifdef LCD_I2C_MASTER_IRQ_EN
    chk("irq_set", {31'd0, irq}, 32'd1);
    bus_rd(2'd2, v); chk("irq_status", {31'd0, v[2]}, 32'd1);
    bus_wr(2'd2, 32'd0);
    chk("irq_clear", {31'd0, irq}, 32'd0);
`endif

    // START|WR 0x3C, slave NACKs, bus left with SCL low; then STOP alone.
    slv_ack = 1'b0;
    bus_wr(2'd0, 32'h0000_003C);
    bus_wr(2'd1, 32'h05);
    wait_idle(1000, n);
    chk("nack_duration", n, 32'd160);
    bus_rd(2'd2, v); chk("nack_status", v & 32'h3, 32'd2);
    chk("nack_scl_held", {31'd0, scl_oe}, 32'd1);
    chk("nack_bits", {24'd0, slv_rx}, 32'h3C);
    s0 = stop_cnt;
    bus_wr(2'd1, 32'h02);
    wait_idle(1000, n);
    chk("stop_duration", n, 32'd16);
    chk("stop_seen", stop_cnt - s0, 32'd1);
    chk("stop_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

    // START|STOP|RD|NACK_OUT, slave sends 0x5A.
    slv_read = 1'b1; slv_tx = 8'h5A;
    bus_wr(2'd1, 32'h1B);
    wait_idle(1000, n);
    chk("rd_duration", n, 32'd176);
    bus_rd(2'd0, v); chk("rd_data", v, 32'h5A);
    chk("rd_nack_out", {31'd0, slv_ack_seen}, 32'd1);
    bus_rd(2'd2, v); chk("rd_keeps_rx_nack", v & 32'h3, 32'd2);
    chk("rd_end_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

    // Clock stretching: slave holds SCL low 40 cycles at bit 3 of a WR.
    slv_read = 1'b0; slv_ack = 1'b1;
    c0 = chg_cnt;
    bus_wr(2'd0, 32'h0000_0096);
    bus_wr(2'd1, 32'h07);
    fork
      wait_idle(2000, n);
      begin : b_stretch
        int k;
        k = 0;
        repeat (16) @(posedge clk);
        while ((slv_r != 3) && (k < 200)) begin @(posedge clk); #1; k++; end
        while (scl_bus && (k < 400)) begin @(posedge clk); #1; k++; end
        scl_hold = 1'b1;
        while (scl_oe && (k < 600)) begin @(posedge clk); #1; k++; end
        repeat (40) @(posedge clk);
        #1 scl_hold = 1'b0;
      end
    join
    chk("stretch_duration", n, 32'd216);
    chk("stretch_sda_hi_changes", chg_cnt - c0, 32'd2);
    chk("stretch_bits", {24'd0, slv_rx}, 32'h96);
    bus_rd(2'd2, v); chk("stretch_status", v & 32'h3, 32'd0);

    // CMD while busy is ignored.
    bus_wr(2'd1, 32'h03);
    repeat (9) @(posedge clk);
    bus_wr(2'd1, 32'h07);
    bus_rd(2'd2, v); chk("busy_write_busy", {31'd0, v[0]}, 32'd1);
    wait_idle(1000, n);
    chk("busy_write_duration", n, 32'd22);
    repeat (5) @(posedge clk);
    #1;
    bus_rd(2'd2, v); chk("busy_write_no_relaunch", v & 32'h3, 32'd0);
    chk("busy_write_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

    // WR|RD together while idle is ignored.
    r0 = slv_r; c0 = chg_cnt;
    bus_wr(2'd1, 32'h0C);
    bus_rd(2'd2, v); chk("wrrd_busy", {31'd0, v[0]}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    bus_rd(2'd2, v); chk("wrrd_busy_later", {31'd0, v[0]}, 32'd0);
    chk("wrrd_no_bus", (slv_r - r0) + (chg_cnt - c0), 32'd0);
    chk("wrrd_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

    // Reset at quarter 20 of a WR byte (bit 5, q0), then a clean START|STOP.
    bus_wr(2'd0, 32'h0000_0000);
    bus_wr(2'd1, 32'h05);
    repeat (96) @(posedge clk);
    #2;
    chk("pre_reset_lines", {30'd0, scl_oe, sda_oe}, 32'd3);
    reset = 1'b1;
    #1;
    chk("reset_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
    bus_rd(2'd2, v); chk("reset_status", v, 32'd0);
    bus_rd(2'd0, v); chk("reset_data", v, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus_wr(2'd1, 32'h03);
    wait_idle(1000, n);
    chk("post_reset_duration", n, 32'd32);
    chk("post_reset_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
